// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the instruction-fetch port
// and the MEM-stage load/store port. Every access is a fixed window of
// WAIT_CYCLES+1 driven RAM cycles followed by a one-cycle completion pulse
// on the owning port. The data port always wins arbitration in IDLE.
module mem_arbiter #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_done,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              ram_en,
   output logic              ram_oe,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam logic       STATE_IDLE = 1'b0;
   localparam logic       STATE_BUSY = 1'b1;
   localparam logic [2:0] WAIT_INIT  = 3'(WAIT_CYCLES);

   logic              state_q,     state_d;
   logic [2:0]        cnt_q,       cnt_d;
   logic              owner_mem_q, owner_mem_d;
   logic              ram_en_q,    ram_en_d;
   logic              ram_oe_q,    ram_oe_d;
   logic              ram_we_q,    ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
   logic              if_valid_q,  if_valid_d;
   logic              mem_done_q,  mem_done_d;

   // A request is masked in the cycle its own completion pulse is high so a
   // still-held request is not issued a second time.
   logic mem_req_live;
   logic if_req_live;

   assign mem_req_live = (mem_rd | mem_wr) & ~mem_done_q;
   assign if_req_live  = if_req & ~if_valid_q;

   // Next-state logic: arbitration and latching in IDLE, countdown and
   // completion in BUSY. RAM-side registers only change at grant or finish.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      owner_mem_d = owner_mem_q;
      ram_en_d    = ram_en_q;
      ram_oe_d    = ram_oe_q;
      ram_we_d    = ram_we_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      if_valid_d  = 1'b0;
      mem_done_d  = 1'b0;

      case (state_q)
         STATE_IDLE: begin
            if (mem_req_live) begin
               owner_mem_d = 1'b1;
               ram_en_d    = 1'b1;
               ram_oe_d    = ~mem_wr;
               ram_we_d    = mem_wr;
               ram_addr_d  = mem_addr;
               if (mem_wr) begin
                  ram_wdata_d = mem_wdata;
               end
               cnt_d       = WAIT_INIT;
               state_d     = STATE_BUSY;
            end else if (if_req_live) begin
               owner_mem_d = 1'b0;
               ram_en_d    = 1'b1;
               ram_oe_d    = 1'b1;
               ram_we_d    = 1'b0;
               ram_addr_d  = if_addr;
               cnt_d       = WAIT_INIT;
               state_d     = STATE_BUSY;
            end
         end
         STATE_BUSY: begin
            if (cnt_q != 3'd0) begin
               cnt_d = cnt_q - 3'd1;
            end else begin
               if (owner_mem_q) begin
                  if (!ram_we_q) begin
                     mem_rdata_d = ram_rdata;
                  end
                  mem_done_d = 1'b1;
               end else begin
                  if_rdata_d = ram_rdata;
                  if_valid_d = 1'b1;
               end
               ram_en_d = 1'b0;
               ram_oe_d = 1'b0;
               ram_we_d = 1'b0;
               state_d  = STATE_IDLE;
            end
         end
      endcase
   end

   // State and output registers; reset abandons any access immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= STATE_IDLE;
         cnt_q       <= 3'd0;
         owner_mem_q <= 1'b0;
         ram_en_q    <= 1'b0;
         ram_oe_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         if_valid_q  <= 1'b0;
         mem_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         owner_mem_q <= owner_mem_d;
         ram_en_q    <= ram_en_d;
         ram_oe_q    <= ram_oe_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         if_valid_q  <= if_valid_d;
         mem_done_q  <= mem_done_d;
      end
   end

   assign if_rdata  = if_rdata_q;
   assign if_valid  = if_valid_q;
   assign mem_rdata = mem_rdata_q;
   assign mem_done  = mem_done_q;
   assign ram_en    = ram_en_q;
   assign ram_oe    = ram_oe_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign stall_if  = if_req & ~if_valid_q;
   assign stall_mem = (mem_rd | mem_wr) & ~mem_done_q;

endmodule
